// File: rtl/multu_hilo_if.sv
// EX-stage side of the MULTU / MFHI / MFLO unit: operands in, HI/LO and stall status out.
// Handshake: a start pulse is taken only at an edge where busy=0. Any start seen while busy=1 is dropped.
// done pulses for one cycle when new hi/lo first appear. stall_req is a pure function of mf_req, busy and start.
interface multu_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             mf_req;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             stall_req;

  modport master (
    output start, op_a, op_b, mf_req,
    input  busy, done, hi, lo, stall_req
  );

  modport slave (
    input  start, op_a, op_b, mf_req,
    output busy, done, hi, lo, stall_req
  );
endinterface

// File: rtl/multu_hilo_unit.sv
// Iterative shift-add unsigned multiplier with the HI/LO register pair.
// Each multiply takes WIDTH iterations. hi/lo keep the previous product until the final iteration.
module multu_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  multu_hilo_if.slave    bus,
  output logic           state_dbg
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  // The add for the current iteration is folded into the same value that the last edge commits to hi/lo.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mcand  <= {{WIDTH{1'b0}}, bus.op_a};
            mplier <= bus.op_b;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            hi_q   <= acc_next[2*WIDTH-1:WIDTH];
            lo_q   <= acc_next[WIDTH-1:0];
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.stall_req = bus.mf_req & (busy_q | bus.start);
  assign state_dbg     = (state == RUN);
endmodule
